// File: rtl/rom_arb_pkg.sv
// Shared definitions for the ROM burst arbiter: state encoding,
// default geometry and requester IDs.
package rom_arb_pkg;

    localparam int AW_DEF    = 32;
    localparam int DW_DEF    = 32;
    localparam int DEPTH_DEF = 256;
    localparam int LW_DEF    = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_LOAD  = 1'b1;

endpackage

// File: rtl/rom_arb_ctrl_rr_arb2.sv
// Two-way round-robin pick: a lone request always wins, a tie goes to
// the requester that was not granted last.
module rr_arb2
    import rom_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant,
    output logic       id
);

    always_comb begin
        grant = 2'b00;
        id    = REQ_FETCH;
        case (req)
            2'b01: begin
                grant = 2'b01;
                id    = REQ_FETCH;
            end
            2'b10: begin
                grant = 2'b10;
                id    = REQ_LOAD;
            end
            2'b11: begin
                if (last == REQ_FETCH) begin
                    grant = 2'b10;
                    id    = REQ_LOAD;
                end else begin
                    grant = 2'b01;
                    id    = REQ_FETCH;
                end
            end
            default: begin
                grant = 2'b00;
                id    = REQ_FETCH;
            end
        endcase
    end

endmodule

// File: rtl/rom_arb_ctrl.sv
// Round-robin burst sequencer sharing one combinational ROM between the
// fetch unit and the loader port; returns registered data per requester.
module rom_arb_ctrl
    import rom_arb_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int LW    = LW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    input  logic [LW-1:0] len0,
    output logic          gnt0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    input  logic [LW-1:0] len1,
    output logic          gnt1,
    output logic [AW-1:0] rom_a,
    input  logic [DW-1:0] rom_rd,
    output logic [DW-1:0] rdata,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic          rlast,
    output logic          rerr
);

    state_t        state_reg, state_next;
    logic [AW-1:0] cur_addr_reg;
    logic [AW-1:0] rom_a_hold_reg;
    logic [LW-1:0] beats_left_reg;
    logic          owner_reg;
    logic          last_reg;
    logic [DW-1:0] rdata_reg;
    logic          rvalid0_reg, rvalid1_reg, rlast_reg, rerr_reg;

    logic [1:0]    arb_grant;
    logic          arb_id;
    logic          grant_now;
    logic          in_range;

    rr_arb2 u_arb (
        .req   ({req1, req0}),
        .last  (last_reg),
        .grant (arb_grant),
        .id    (arb_id)
    );

    // Full-width compare so high address bits never alias into the ROM.
    assign in_range  = (cur_addr_reg < AW'(DEPTH));
    assign grant_now = (state_reg == IDLE) && (arb_grant != 2'b00) && rst_n;

    always_comb begin
        state_next = state_reg;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_now) begin
                    gnt0       = arb_grant[0];
                    gnt1       = arb_grant[1];
                    state_next = BURST;
                end
            end
            BURST: begin
                if (beats_left_reg == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cur_addr_reg   <= '0;
            rom_a_hold_reg <= '0;
            beats_left_reg <= '0;
            owner_reg      <= REQ_FETCH;
            last_reg       <= REQ_LOAD;
            rdata_reg      <= '0;
            rvalid0_reg    <= 1'b0;
            rvalid1_reg    <= 1'b0;
            rlast_reg      <= 1'b0;
            rerr_reg       <= 1'b0;
        end else begin
            state_reg   <= state_next;
            rvalid0_reg <= 1'b0;
            rvalid1_reg <= 1'b0;
            rlast_reg   <= 1'b0;
            rerr_reg    <= 1'b0;
            if (grant_now) begin
                cur_addr_reg   <= arb_id ? addr1 : addr0;
                beats_left_reg <= arb_id ? len1 : len0;
                owner_reg      <= arb_id;
                last_reg       <= arb_id;
            end
            if (state_reg == BURST) begin
                rdata_reg      <= in_range ? rom_rd : '0;
                rvalid0_reg    <= (owner_reg == REQ_FETCH);
                rvalid1_reg    <= (owner_reg == REQ_LOAD);
                rerr_reg       <= !in_range;
                rlast_reg      <= (beats_left_reg == '0);
                cur_addr_reg   <= cur_addr_reg + AW'(1);
                beats_left_reg <= beats_left_reg - LW'(1);
                rom_a_hold_reg <= cur_addr_reg;
            end
        end
    end

    // Outside a burst the ROM keeps seeing the last issued address.
    assign rom_a   = (state_reg == BURST) ? cur_addr_reg : rom_a_hold_reg;
    assign rdata   = rdata_reg;
    assign rvalid0 = rvalid0_reg;
    assign rvalid1 = rvalid1_reg;
    assign rlast   = rlast_reg;
    assign rerr    = rerr_reg;

endmodule
